// File: rtl/nn_img_loader_pkg.sv
// Shared constants, FSM state type and pixel quantisation for nn_img_loader.
package nn_pkg;

  localparam int unsigned N_PIX = 784;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned IDX_W = 10;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_RESULT
  } state_t;

  // Unsigned 0..255 grey level halved into the non-negative half of int8.
  function automatic logic signed [PIX_W-1:0] pix_to_s8(input logic [PIX_W-1:0] p);
    return $signed({1'b0, p[PIX_W-1:1]});
  endfunction

endpackage

// File: rtl/nn_img_loader_if.sv
// Pixel stream valid/ready handshake between an image source and nn_img_loader.
interface nn_img_loader_if;

  logic                       pix_valid;
  logic [nn_pkg::PIX_W-1:0]   pix_data;
  logic                       pix_ready;

  modport master (output pix_valid, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_data, output pix_ready);

endinterface

// File: rtl/nn_img_loader.sv
// Streams one frame into the img buffer, starts the network and latches its class.
// Optional macro NN_TIMEOUT_EN adds a RUN-state watchdog of TIMEOUT_CYCLES.
module nn_img_loader #(
  parameter int unsigned N_PIX          = nn_pkg::N_PIX,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                              clk,
  input  logic                              reset,
  nn_img_loader_if.slave                    pix,
  output logic signed [nn_pkg::PIX_W-1:0]   img [0:N_PIX-1],
  output logic                              nn_enable,
  input  logic                              nn_done,
  input  logic [7:0]                        digit_in,
  output logic                              result_valid,
  output logic [3:0]                        result_digit,
  output logic                              result_err,
  output logic                              busy
);
  import nn_pkg::*;

  if (N_PIX < 2 || N_PIX > (1 << IDX_W)) begin : g_bad_npix
    $error("nn_img_loader: N_PIX out of range for the pixel index");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("nn_img_loader: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_pix_ready;
  logic               r_armed;
  logic               w_xfer;
  logic               w_idx_last;

`ifdef NN_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]        r_tcnt;
`endif

  assign pix.pix_ready = r_pix_ready;
  assign w_xfer        = pix.pix_valid && r_pix_ready;
  assign w_idx_last    = (r_idx == IDX_W'(N_PIX - 1));

  // Frame buffer has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      img[r_idx] <= pix_to_s8(pix.pix_data);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_LOAD;
      r_idx        <= '0;
      r_pix_ready  <= 1'b1;
      r_armed      <= 1'b0;
      nn_enable    <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_digit <= '0;
      result_err   <= 1'b0;
`ifdef NN_TIMEOUT_EN
      r_tcnt       <= '0;
`endif
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_xfer) begin
            if (w_idx_last) begin
              r_idx       <= '0;
              r_state     <= ST_RUN;
              r_pix_ready <= 1'b0;
              nn_enable   <= 1'b1;
              busy        <= 1'b1;
              r_armed     <= 1'b0;
`ifdef NN_TIMEOUT_EN
              r_tcnt      <= '0;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        ST_RUN: begin
          // A done seen on the first RUN cycle belongs to the previous job.
          r_armed <= 1'b1;
`ifdef NN_TIMEOUT_EN
          r_tcnt  <= r_tcnt + 1'b1;
`endif
          if (r_armed && nn_done) begin
            result_digit <= digit_in[3:0];
            result_err   <= (digit_in > 8'd9);
            result_valid <= 1'b1;
            nn_enable    <= 1'b0;
            busy         <= 1'b0;
            r_pix_ready  <= 1'b1;
            r_state      <= ST_RESULT;
          end
`ifdef NN_TIMEOUT_EN
          else if (r_tcnt == TO_LAST) begin
            result_digit <= 4'hF;
            result_err   <= 1'b1;
            result_valid <= 1'b1;
            nn_enable    <= 1'b0;
            busy         <= 1'b0;
            r_pix_ready  <= 1'b1;
            r_state      <= ST_RESULT;
          end
`endif
        end

        ST_RESULT: begin
          // The accepting transfer already wrote img[0], so the next frame resumes at 1.
          if (w_xfer) begin
            result_valid <= 1'b0;
            r_idx        <= IDX_W'(1);
            r_state      <= ST_LOAD;
          end
        end

        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_img_loader.sv
// Randomised bench for nn_img_loader against a frame-level reference model.
module tb_nn_img_loader;
  import nn_pkg::*;

  localparam int NP = 784;
`ifdef NN_TIMEOUT_EN
  localparam int TB_TO = 100;
`else
  localparam int TB_TO = 65535;
`endif

  logic clk = 1'b0;
  logic reset;
  logic nn_enable, nn_done, result_valid, result_err, busy;
  logic [7:0] digit_in;
  logic [3:0] result_digit;
  logic signed [7:0] img [0:NP-1];

  nn_img_loader_if pif ();

  nn_img_loader #(
    .N_PIX          (NP),
    .TIMEOUT_CYCLES (TB_TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pix          (pif.slave),
    .img          (img),
    .nn_enable    (nn_enable),
    .nn_done      (nn_done),
    .digit_in     (digit_in),
    .result_valid (result_valid),
    .result_digit (result_digit),
    .result_err   (result_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_img [NP];
  int exp_digit = 0;
  int exp_err = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_img(input string tag);
    for (int i = 0; i < NP; i++)
      check_val($sformatf("%s_img[%0d]", tag, i), int'(img[i]), exp_img[i]);
  endtask

  // mode 0: all 255; mode 1: random with 200 first and 1 last; mode 2: random.
  task automatic send_frame(input int gap, input int mode, input int count);
    int data [NP];
    for (int i = 0; i < NP; i++)
      data[i] = (mode == 0) ? 255 : int'($urandom_range(0, 255));
    if (mode == 1) begin
      data[0]    = 200;
      data[NP-1] = 1;
    end
    for (int k = 0; k < count; k++) begin
      int g = 0;
      bit v;
      do begin
        @(negedge clk);
        g++;
        if (g == 1 && k == 0)      check_val("ready_first", int'(pif.pix_ready), 1);
        if (g == 1 && k == 1)      check_val("valid_clear", int'(result_valid), 0);
        if (g == 1 && k == NP / 2) check_val("busy_load", int'(busy), 0);
        v = (g > 20) || ($urandom_range(0, 99) >= gap);
        pif.pix_valid = v;
        pif.pix_data  = v ? 8'(data[k]) : 8'($urandom);
        nn_done       = ($urandom_range(0, 3) == 0);
        digit_in      = 8'($urandom);
      end while (!v);
      exp_img[k] = data[k] / 2;
    end
    if (count == NP) begin
      @(negedge clk);
      // Keep offering pixels during RUN; none may be accepted.
      pif.pix_valid = 1'b1;
      pif.pix_data  = 8'($urandom);
      nn_done       = 1'b0;
      check_val("run_enable", int'(nn_enable), 1);
      check_val("run_busy", int'(busy), 1);
      check_val("run_ready", int'(pif.pix_ready), 0);
      check_val("run_valid", int'(result_valid), 0);
      check_val("run_digit_held", int'(result_digit), exp_digit);
    end
  endtask

  task automatic finish_result(input string tag);
    check_val({tag, "_valid"}, int'(result_valid), 1);
    check_val({tag, "_digit"}, int'(result_digit), exp_digit);
    check_val({tag, "_err"}, int'(result_err), exp_err);
    check_val({tag, "_enable"}, int'(nn_enable), 0);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_ready"}, int'(pif.pix_ready), 1);
    // Late done pulses in RESULT must not disturb the held class.
    repeat (3) begin
      @(negedge clk);
      nn_done  = 1'b1;
      digit_in = 8'($urandom);
    end
    @(negedge clk);
    nn_done = 1'b0;
    check_val({tag, "_hold_digit"}, int'(result_digit), exp_digit);
    check_val({tag, "_hold_valid"}, int'(result_valid), 1);
  endtask

  // Called on the negedge right after the last pixel edge (first RUN cycle).
  task automatic run_nn(input string tag, input int wait_n, input logic [7:0] d, input bit stale);
    if (stale) begin
      nn_done  = 1'b1;
      digit_in = 8'd3;
    end
    @(negedge clk);
    nn_done = 1'b0;
    check_val({tag, "_stale_enable"}, int'(nn_enable), 1);
    check_val({tag, "_stale_valid"}, int'(result_valid), 0);
    repeat (wait_n) begin
      @(negedge clk);
      pif.pix_data = 8'($urandom);
    end
    check_val({tag, "_wait_enable"}, int'(nn_enable), 1);
    nn_done  = 1'b1;
    digit_in = d;
    @(negedge clk);
    nn_done       = 1'b0;
    pif.pix_valid = 1'b0;
    exp_digit = int'(d[3:0]);
    exp_err   = (d > 8'd9) ? 1 : 0;
    finish_result(tag);
    check_img({tag, "_post"});
  endtask

  task automatic apply_reset_now(input string tag);
    reset = 1'b1;
    #1;
    exp_digit = 0;
    exp_err   = 0;
    check_val({tag, "_enable"}, int'(nn_enable), 0);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_valid"}, int'(result_valid), 0);
    check_val({tag, "_digit"}, int'(result_digit), 0);
    check_val({tag, "_err"}, int'(result_err), 0);
    check_val({tag, "_ready"}, int'(pif.pix_ready), 1);
    @(negedge clk);
    reset         = 1'b0;
    pif.pix_valid = 1'b0;
    nn_done       = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    pif.pix_valid = 1'b0;
    pif.pix_data  = '0;
    nn_done       = 1'b0;
    digit_in      = '0;
    repeat (3) @(negedge clk);
    check_val("rst_enable", int'(nn_enable), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_valid", int'(result_valid), 0);
    check_val("rst_digit", int'(result_digit), 0);
    check_val("rst_err", int'(result_err), 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_ready", int'(pif.pix_ready), 1);

    send_frame(0, 0, NP);
    check_img("sat");
    run_nn("d7", 50, 8'd7, 1'b1);

    send_frame(30, 1, NP);
    check_val("edge_img0", int'(img[0]), 100);
    check_val("edge_img783", int'(img[NP-1]), 0);
    check_img("gap");
    run_nn("d12", int'($urandom_range(1, 30)), 8'd12, 1'b0);

`ifdef NN_TIMEOUT_EN
    begin
      int n = 0;
      send_frame(20, 2, NP);
      pif.pix_valid = 1'b0;
      while (!result_valid && n < 300) begin
        @(negedge clk);
        n++;
      end
      exp_digit = 15;
      exp_err   = 1;
      check_val("to_cycles", n, TB_TO);
      finish_result("to");
    end
`endif

    send_frame(30, 2, NP);
    repeat (5) @(negedge clk);
    apply_reset_now("rst_run");

    send_frame(30, 2, 300);
    apply_reset_now("rst_load");

    send_frame(10, 2, NP);
    check_img("after_rst");
    run_nn("rnd", int'($urandom_range(1, 40)), 8'($urandom_range(0, 15)), 1'b1);

    send_frame(50, 2, NP);
    check_img("gap50");
    run_nn("wide", int'($urandom_range(1, 40)), 8'($urandom_range(0, 255)), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/nn_img_loader.md
NN_IMG_LOADER -- requirements
Module: nn_img_loader

Interface
REQ-001 Parameter N_PIX, default 784, SHALL be the pixels per frame (28x28).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, SHALL be the maximum wait for nn_done; used only when NN_TIMEOUT_EN is defined.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 pix_valid  input  1  SHALL be the upstream pixel-valid flag.
REQ-006 pix_data  input  8  SHALL be the unsigned grayscale pixel, 0..255, row-major.
REQ-007 pix_ready  output  1  SHALL be high when a pixel can be accepted.
REQ-008 img  output  signed 8 x N_PIX (unpacked [0:N_PIX-1])  SHALL be the frame buffer driven to the network.
REQ-009 nn_enable  output  1  SHALL be the network start level.
REQ-010 nn_done  input  1  SHALL be the network completion flag.
REQ-011 digit_in  input  8  SHALL be the network classification output.
REQ-012 result_valid  output  1  SHALL flag a held result.
REQ-013 result_digit  output  4  SHALL be the latched class, 0..9.
REQ-014 result_err  output  1  SHALL flag a bad class (digit_in > 9) or, with NN_TIMEOUT_EN, a timeout.
REQ-015 busy  output  1  SHALL be high in RUN.

Function
REQ-016 FSM states SHALL be LOAD, RUN, RESULT; reset state LOAD.
REQ-017 LOAD: pix_ready=1; a transfer occurs when pix_valid && pix_ready; pixel k is written to img[k] as {1'b0, pix_data[7:1]} (range 0..127, never negative).
REQ-018 The 10-bit pixel index SHALL increment per transfer; the transfer at index N_PIX-1 clears the index to 0 and moves to RUN on the next edge.
REQ-019 pix_valid low in LOAD SHALL stall the index with no img write; there is no timeout while loading.
REQ-020 RUN: pix_ready=0, busy=1, nn_enable=1 registered, asserted on the first RUN cycle and held; img SHALL NOT change.
REQ-021 In RUN, the first cycle with nn_done=1 SHALL latch result_digit=digit_in[3:0] and result_err=(digit_in>9), drop nn_enable, and enter RESULT on that edge.
REQ-022 nn_done=1 on the entry cycle into RUN SHALL be ignored (stale completion); sampling starts one cycle after nn_enable rises.
REQ-023 RESULT: result_valid=1, pix_ready=1; the first accepted pixel SHALL write img[0], clear result_valid, and enter LOAD with index 1.
REQ-024 Latency: the last pixel accepted at cycle T gives nn_enable=1 at T+1; nn_done sampled high at cycle D gives result_valid=1 at D+1.
REQ-025 nn_done while in LOAD or RESULT SHALL be ignored.

Reset
REQ-026 Assertion SHALL immediately force state LOAD, index 0, nn_enable=0, pix_ready=1 after release, result_valid=0, result_digit=0, result_err=0, busy=0, timeout counter 0.
REQ-027 img contents SHALL NOT be reset (RAM-inferable); reset mid-LOAD or mid-RUN SHALL abort the frame, and the next frame overwrites img from index 0.

Configuration
REQ-028 With NN_TIMEOUT_EN defined, a 16-bit counter SHALL count RUN cycles; reaching TIMEOUT_CYCLES without nn_done SHALL drop nn_enable, set result_err=1 and result_digit=4'hF, and enter RESULT.
REQ-029 Without NN_TIMEOUT_EN, no counter SHALL exist and RUN waits indefinitely for nn_done.

Structure
REQ-030 Package nn_pkg SHALL hold N_PIX, PIX_W=8, the state enum type, and the pixel-to-signed quantisation function.
REQ-031 No sub-module; the img array is inline; the network instance is external to this block.

Verification
REQ-032 Stream 784 pixels of value 255 back to back -> every img entry is 127; nn_enable rises one cycle after the last transfer; pix_ready=0.
REQ-033 nn_done=1 with digit_in=7 after 50 RUN cycles -> next cycle result_valid=1, result_digit=7, result_err=0, nn_enable=0.
REQ-034 digit_in=12 at nn_done -> result_digit=12 (4'hC), result_err=1.
REQ-035 Random pix_valid gaps (~30% low), pixel 200 at index 0 and 1 at index 783 -> img[0]=100, img[783]=0; no extra or missing writes.
REQ-036 Reset asserted mid-RUN at pixel count 784 -> nn_enable=0 without a clock edge; a new 784-pixel frame restarts at index 0.
REQ-037 NN_TIMEOUT_EN with TIMEOUT_CYCLES=100 and nn_done held low -> after 100 RUN cycles result_err=1, result_digit=15, state RESULT.
